time_keeper: RTL and testbench
==============================

Name: time_keeper

Overview:
- Timekeeping stage directly upstream of the seven-segment display driver.
- Prescales the system clock into 1-second ticks and keeps an mm:ss count, minutes and seconds each 0..59.
- Presents the count packed as data_show[11:0]: minutes in [11:6], seconds in [5:0].
- Generates the free-running 3-bit display scan phase byte_status consumed by the display driver.
- Accepts two asynchronous push-button inputs for manual time setting.

Parameters:
- TICK_DIV, 1000: clock cycles per second tick; must be >= 2.
- SCAN_DIV, 16: clock cycles per byte_status step; must be >= 1.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous active-low reset.
- run  input  1  synchronous; 1 = time advances on ticks, 0 = count and prescaler frozen.
- inc_sec  input  1  asynchronous push button; each rising edge adds 1 to seconds.
- inc_min  input  1  asynchronous push button; each rising edge adds 1 to minutes.
- data_show  output  12  {minutes[5:0], seconds[5:0]}, registered.
- byte_status  output  3  display scan phase 0..7, registered.
- sec_tick  output  1  one-cycle pulse on every 1 s tick, registered.
- min_wrap  output  1  one-cycle pulse when a tick carry wraps minutes 59->0, registered.

Behaviour:
- Reset (reset=0, asynchronous): all state and all outputs go to 0 immediately. This includes prescaler, scan divider, synchronizer flops, data_show, byte_status, sec_tick and min_wrap. Reset asserted mid-operation discards any partially counted second.
- Prescaler:
  - ceil(log2(TICK_DIV)) bits.
  - With run=1: increments each cycle. At TICK_DIV-1 it returns to 0, and tick=1 for that cycle.
  - With run=0: holds its value, and tick=0.
- sec_tick: registered copy of tick, high for exactly 1 cycle, in the same cycle the seconds update becomes visible.
- Seconds: on tick, 0..58 -> +1. At 59 -> 0, and a carry adds 1 to minutes on the same edge.
- Minutes: on carry, 0..58 -> +1. At 59 -> 0, with min_wrap=1 for 1 cycle, aligned with sec_tick.
- Buttons:
  - Each button passes through a 2-flop synchronizer, then a third flop for edge detection. pulse = s2 & ~s3.
  - Field update happens on the edge where pulse=1, so data_show changes on the 3rd rising edge after the input first samples high.
  - Holding a button gives exactly one increment.
  - No debounce in this block; a bouncing input gives multiple increments.
  - Buttons act regardless of run.
- Manual increments:
  - inc_sec at 59 -> 0 with no carry into minutes.
  - inc_min at 59 -> 0 with no min_wrap.
- Collisions:
  - Tick and inc_sec pulse in the same cycle: seconds advance by exactly 1. A carry occurs only if seconds was 59, via the tick path.
  - Carry and inc_min pulse in the same cycle: minutes advance by exactly 1.
  - inc_sec and inc_min in the same cycle: both fields increment independently.
- Scan counter:
  - Divider counts 0..SCAN_DIV-1. On wrap, byte_status increments, 7 -> 0.
  - Free-running and independent of run and buttons. With SCAN_DIV=1, byte_status steps every cycle.
- Values stay within range: data_show fields never exceed 59 under any input sequence.

Test Plan:
- Reset, then run=1 with TICK_DIV=4 for 16 cycles -> sec_tick pulses every 4th cycle, and data_show[5:0] counts 1,2,3,4. Assert reset mid-count -> data_show=0 immediately.
- Preload 00:59 via 59 inc_sec presses, then one tick -> data_show=12'h040 (01:00), sec_tick=1, min_wrap=0.
- Preload 59:59 via 59 inc_min and 59 inc_sec presses, then one tick -> data_show=0, sec_tick=1 and min_wrap=1 in the same cycle.
- run=0 for 100 cycles -> data_show and prescaler unchanged, no sec_tick. Hold inc_min high 50 cycles -> minutes +1 exactly, visible on the 3rd edge after assertion.
- With seconds=59, align the inc_sec pulse with tick -> seconds=0 and minutes +1 (single carry). With seconds=10, same alignment -> seconds=11.
- SCAN_DIV=2 for 20 cycles -> byte_status steps every 2 cycles through 0..7 and wraps to 0, unaffected by run toggling.

Source files
------------

// File: rtl/time_keeper_if.sv
// Signal bundle between the timekeeping stage and its controller/display side.
// The slave modport is the time_keeper view; master is the driving side.
interface time_keeper_if;
  logic        run;
  logic        inc_sec;
  logic        inc_min;
  logic [11:0] data_show;
  logic [2:0]  byte_status;
  logic        sec_tick;
  logic        min_wrap;

  modport master (
    output run, inc_sec, inc_min,
    input  data_show, byte_status, sec_tick, min_wrap
  );

  modport slave (
    input  run, inc_sec, inc_min,
    output data_show, byte_status, sec_tick, min_wrap
  );
endinterface

// File: rtl/time_keeper.sv
// mm:ss timekeeper: prescales the clock to 1 s ticks, accepts push-button time
// setting and produces the free-running display scan phase.
module time_keeper #(
  parameter int TICK_DIV = 1000,
  parameter int SCAN_DIV = 16
) (
  input  logic         clock,
  input  logic         reset,
  time_keeper_if.slave tk
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [5:0]    FIELD_MAX = 6'd59;

  // Saturating-safe modulo-60 increment: any out-of-range value returns to 0.
  function automatic logic [5:0] field_inc(input logic [5:0] v);
    logic [5:0] r;
    if (v >= FIELD_MAX) begin
      r = 6'd0;
    end else begin
      r = v + 6'd1;
    end
    return r;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    scan_q, scan_d;
  logic [2:0]    sec_sync_q, min_sync_q;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic          sec_tick_q, sec_tick_d;
  logic          min_wrap_q, min_wrap_d;

  logic tick_s;
  logic carry_s;
  logic sec_pulse_s;
  logic min_pulse_s;

  // Edge pulses from synchronizer stages: [1] is the second sync flop, [2] the edge flop.
  assign sec_pulse_s = sec_sync_q[1] & ~sec_sync_q[2];
  assign min_pulse_s = min_sync_q[1] & ~min_sync_q[2];
  assign tick_s      = tk.run & (presc_q == PRESC_MAX);
  assign carry_s     = tick_s & (sec_q == FIELD_MAX);

  // Prescaler next state: frozen while not running.
  always_comb begin
    presc_d = presc_q;
    if (tk.run) begin
      if (tick_s) begin
        presc_d = {PW{1'b0}};
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = presc_q;
    end
  end

  // Time fields: a tick and a button pulse together still advance by one; only ticks carry.
  always_comb begin
    sec_d      = sec_q;
    min_d      = min_q;
    sec_tick_d = tick_s;
    min_wrap_d = carry_s & (min_q == FIELD_MAX);
    if (tick_s | sec_pulse_s) begin
      sec_d = field_inc(sec_q);
    end else begin
      sec_d = sec_q;
    end
    if (carry_s | min_pulse_s) begin
      min_d = field_inc(min_q);
    end else begin
      min_d = min_q;
    end
  end

  // Scan divider and phase, independent of run and buttons.
  always_comb begin
    scan_cnt_d = scan_cnt_q;
    scan_d     = scan_q;
    if (scan_cnt_q == SCAN_MAX) begin
      scan_cnt_d = {SW{1'b0}};
      scan_d     = scan_q + 3'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + SW'(1);
      scan_d     = scan_q;
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q    <= {PW{1'b0}};
      scan_cnt_q <= {SW{1'b0}};
      scan_q     <= 3'd0;
      sec_sync_q <= 3'd0;
      min_sync_q <= 3'd0;
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      sec_tick_q <= 1'b0;
      min_wrap_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      scan_cnt_q <= scan_cnt_d;
      scan_q     <= scan_d;
      sec_sync_q <= {sec_sync_q[1:0], tk.inc_sec};
      min_sync_q <= {min_sync_q[1:0], tk.inc_min};
      sec_q      <= sec_d;
      min_q      <= min_d;
      sec_tick_q <= sec_tick_d;
      min_wrap_q <= min_wrap_d;
    end
  end

  assign tk.data_show   = {min_q, sec_q};
  assign tk.byte_status = scan_q;
  assign tk.sec_tick    = sec_tick_q;
  assign tk.min_wrap    = min_wrap_q;

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper: a cycle-level reference model queues expected
// outputs; a monitor on the falling edge pops and compares.
module tb_time_keeper;
  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;

  time_keeper_if tkif();

  time_keeper #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clock (clock),
    .reset (reset),
    .tk    (tkif.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] show;
    logic [2:0]  phase;
    logic        tick;
    logic        wrap;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time as minutes/seconds integers, events computed from elapsed cycles.
  int m_sec, m_min, m_cycles, m_runs, m_edge;
  bit m_prev_sec, m_prev_min;
  int due_sec[$];
  int due_min[$];

  initial begin
    exp_t e;
    bit   tick, carry, wrap, bs, bm;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_sec = 0; m_min = 0; m_cycles = 0; m_runs = 0; m_edge = 0;
        m_prev_sec = 1'b0; m_prev_min = 1'b0;
        due_sec.delete(); due_min.delete(); sb_q.delete();
      end else begin
        m_edge++;
        m_cycles++;
        if (tkif.run) m_runs++;
        tick = tkif.run && (m_runs % TICK_DIV == 0);
        bs = (due_sec.size() > 0 && due_sec[0] == m_edge);
        bm = (due_min.size() > 0 && due_min[0] == m_edge);
        if (bs) void'(due_sec.pop_front());
        if (bm) void'(due_min.pop_front());
        // A press first seen at this edge lands two edges later.
        if (tkif.inc_sec && !m_prev_sec) due_sec.push_back(m_edge + 2);
        if (tkif.inc_min && !m_prev_min) due_min.push_back(m_edge + 2);
        m_prev_sec = tkif.inc_sec;
        m_prev_min = tkif.inc_min;
        carry = tick && (m_sec == 59);
        wrap  = carry && (m_min == 59);
        if (tick || bs) m_sec = (m_sec + 1) % 60;
        if (carry || bm) m_min = (m_min + 1) % 60;
        e.show  = {6'(m_min), 6'(m_sec)};
        e.phase = 3'((m_cycles / SCAN_DIV) % 8);
        e.tick  = tick;
        e.wrap  = wrap;
        sb_q.push_back(e);
      end
    end
  end

  // Monitor: every clocked output cycle is compared with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("data_show",   tkif.data_show,           e.show);
        check("byte_status", {9'd0, tkif.byte_status}, {9'd0, e.phase});
        check("sec_tick",    {11'd0, tkif.sec_tick},   {11'd0, e.tick});
        check("min_wrap",    {11'd0, tkif.min_wrap},   {11'd0, e.wrap});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press_sec(input int n);
    repeat (n) begin
      tkif.inc_sec = 1'b1; cyc(4);
      tkif.inc_sec = 1'b0; cyc(4);
    end
  endtask

  task automatic press_min(input int n);
    repeat (n) begin
      tkif.inc_min = 1'b1; cyc(4);
      tkif.inc_min = 1'b0; cyc(4);
    end
  endtask

  // Called on a falling edge: asserts reset between edges and checks the immediate clear.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_data_show", tkif.data_show, 12'h000);
    check("rst_byte_status", {9'd0, tkif.byte_status}, 12'h000);
    check("rst_sec_tick", {11'd0, tkif.sec_tick}, 12'h000);
    cyc(2);
    reset = 1'b1;
  endtask

  task automatic wait_tick(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc(1);
      if (tkif.sec_tick) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_tick: got no sec_tick expected one within %0d cycles", budget);
    end
  endtask

  initial begin
    tkif.run = 1'b0; tkif.inc_sec = 1'b0; tkif.inc_min = 1'b0;
    cyc(3);
    check("init_data_show", tkif.data_show, 12'h000);
    check("init_min_wrap", {11'd0, tkif.min_wrap}, 12'h000);
    reset = 1'b1;

    // Free-running count: four ticks in sixteen cycles.
    tkif.run = 1'b1;
    cyc(16);
    check("count_4", tkif.data_show, 12'h004);
    cyc(2);
    tkif.run = 1'b0;
    do_reset();

    // 00:59 then one tick.
    press_sec(59);
    check("preload_0059", tkif.data_show, 12'h03B);
    tkif.run = 1'b1;
    wait_tick(20);
    check("carry_0100", tkif.data_show, 12'h040);
    check("carry_no_wrap", {11'd0, tkif.min_wrap}, 12'h000);
    tkif.run = 1'b0;

    // 59:59 then one tick.
    press_min(58);
    press_sec(59);
    check("preload_5959", tkif.data_show, 12'hEFB);
    tkif.run = 1'b1;
    wait_tick(20);
    check("wrap_0000", tkif.data_show, 12'h000);
    check("wrap_pulse", {11'd0, tkif.min_wrap}, 12'h001);
    tkif.run = 1'b0;

    // Frozen count, then a held minute button.
    cyc(100);
    check("frozen", tkif.data_show, 12'h000);
    tkif.inc_min = 1'b1;
    cyc(2);
    check("hold_edge2", tkif.data_show, 12'h000);
    cyc(1);
    check("hold_edge3", tkif.data_show, 12'h040);
    cyc(47);
    check("hold_once", tkif.data_show, 12'h040);
    tkif.inc_min = 1'b0;
    cyc(4);

    // Tick and inc_sec pulse on the same edge, seconds at 59 then at 10.
    do_reset();
    press_sec(59);
    tkif.run = 1'b1; cyc(1);
    tkif.inc_sec = 1'b1; cyc(3);
    check("collide_59", tkif.data_show, 12'h040);
    check("collide_tick", {11'd0, tkif.sec_tick}, 12'h001);
    tkif.inc_sec = 1'b0; tkif.run = 1'b0;
    cyc(4);
    do_reset();
    press_sec(10);
    tkif.run = 1'b1; cyc(1);
    tkif.inc_sec = 1'b1; cyc(3);
    check("collide_10", tkif.data_show, 12'h00B);
    tkif.inc_sec = 1'b0; tkif.run = 1'b0;
    cyc(4);

    // Randomised run, button holds and bounces, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      tkif.run = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) tkif.inc_sec = ~tkif.inc_sec;
      if ($urandom_range(0, 11) == 0) tkif.inc_min = ~tkif.inc_min;
      if ($urandom_range(0, 599) == 0) do_reset();
      else cyc(1);
    end
    tkif.run = 1'b0; tkif.inc_sec = 1'b0; tkif.inc_min = 1'b0;
    cyc(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
